// File: rtl/mux_rr_stream_if.sv
// mux_rr_stream_if: stream bundle between CHANNELS producers, the mux and one consumer.
//   in_data/in_valid/in_ready : per-channel input streams (channel k at [k*N +: N])
//   mode/sel                  : 0 = round-robin, 1 = fixed select of channel sel
//   out_data/out_channel/out_valid/out_ready : registered output stream
// slave  : the mux's view of the bundle.
// master : the producers' and consumer's view (drives inputs, observes outputs).
interface mux_rr_stream_if #(
    parameter int  N        = 8,
    parameter int  CHANNELS = 16,
    localparam int SEL_W    = $clog2(CHANNELS)
);
    logic [CHANNELS*N-1:0] in_data;
    logic [CHANNELS-1:0]   in_valid;
    logic [CHANNELS-1:0]   in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N-1:0]          out_data;
    logic [SEL_W-1:0]      out_channel;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_channel, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_channel, out_valid
    );
endinterface

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-bit, CHANNELS-way stream mux with round-robin or fixed-select
// arbitration feeding a one-deep registered output stage with valid/ready backpressure.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : mux_rr_stream_if.slave (input streams, mode/sel, output stream)
//   xfer_count : 16-bit saturating count of output handshakes, present only when
//                the macro MUX_RR_XFER_CNT_EN is defined
module mux_rr_stream #(
    parameter int  N        = 8,
    parameter int  CHANNELS = 16,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef MUX_RR_XFER_CNT_EN
    output logic [15:0]           xfer_count,
`endif
    mux_rr_stream_if.slave        bus
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     data_q,  data_d;
    logic [SEL_W-1:0] chan_q,  chan_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;
    logic             load;

    // Output register can take a new word when empty or being drained this cycle.
    assign load = (state_q == EMPTY) || bus.out_ready;

    // Arbitration. Round-robin scans from ptr upward with an explicit wrap at
    // CHANNELS so non-power-of-two channel counts never visit phantom indices.
    always_comb begin : arb
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (bus.mode) begin
            if (int'(bus.sel) < CHANNELS) begin
                if (bus.in_valid[bus.sel]) begin
                    grant_vld = 1'b1;
                    grant_idx = bus.sel;
                end
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!grant_vld && bus.in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(idx);
                end
            end
        end
    end

    // At most one ready bit; suppressed during reset so nothing is lost mid-reset.
    always_comb begin
        bus.in_ready = '0;
        if (!rst && grant_vld && load) bus.in_ready[grant_idx] = 1'b1;
    end

    // Output-stage FSM next state and datapath.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (grant_vld) begin
                state_d = FULL;
                data_d  = bus.in_data[int'(grant_idx)*N +: N];
                chan_d  = grant_idx;
                // Fixed-select traffic leaves the round-robin position untouched.
                if (!bus.mode)
                    ptr_d = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid   = (state_q == FULL);
    assign bus.out_data    = data_q;
    assign bus.out_channel = chan_q;

`ifdef MUX_RR_XFER_CNT_EN
    logic [15:0] xfer_count_q, xfer_count_d;

    always_comb begin
        xfer_count_d = xfer_count_q;
        if ((state_q == FULL) && bus.out_ready && (xfer_count_q != 16'hFFFF))
            xfer_count_d = xfer_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) xfer_count_q <= '0;
        else     xfer_count_q <= xfer_count_d;
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb_mux_rr_stream: directed scenarios plus a randomized run, each checked against
// a transaction-level model (expected pointer, output word, channel and valid).
module tb_mux_rr_stream;
    localparam int N = 8;
    localparam int C = 16;
    localparam int SW = $clog2(C);

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef MUX_RR_XFER_CNT_EN
    logic [15:0] xfer_count;
`endif

    mux_rr_stream_if #(.N(N), .CHANNELS(C)) bus ();

    mux_rr_stream #(.N(N), .CHANNELS(C)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef MUX_RR_XFER_CNT_EN
        .xfer_count (xfer_count),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_ptr   = 0;
    bit         m_valid = 0;
    logic [N-1:0] m_data = '0;
    int         m_ch    = 0;
    int         m_cnt   = 0;

    function automatic int model_grant();
        if (bus.mode) return (int'(bus.sel) < C && bus.in_valid[bus.sel]) ? int'(bus.sel) : -1;
        for (int i = 0; i < C; i++) begin
            int k;
            k = (m_ptr + i) % C;
            if (bus.in_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [C-1:0] exp_ready();
        logic [C-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (!rst && (!m_valid || bus.out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        int g;
        bit ld;
        logic [N-1:0] d;
        g  = model_grant();
        ld = !m_valid || bus.out_ready;
        d  = (g >= 0) ? bus.in_data[g*N +: N] : '0;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_valid = 0; m_data = '0; m_ch = 0; m_cnt = 0;
        end else begin
            if (m_valid && bus.out_ready && m_cnt != 16'hFFFF) m_cnt++;
            if (ld) begin
                if (g >= 0) begin
                    m_valid = 1; m_data = d; m_ch = g;
                    if (!bus.mode) m_ptr = (g + 1) % C;
                end else begin
                    m_valid = 0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_data_ramp(input logic [N-1:0] base);
        for (int k = 0; k < C; k++) bus.in_data[k*N +: N] = base + N'(k);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = '1; bus.mode = 0; bus.sel = '0; bus.out_ready = 1;
        set_data_ramp(8'h10);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== '0) begin errors++; $display("FAIL reset_in_ready got=%h exp=0", bus.in_ready); end
            tick();
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_channel !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", bus.out_valid, bus.out_data, bus.out_channel);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 16'h0001) begin errors++; $display("FAIL reset_first_grant got=%h exp=0001", bus.in_ready); end
        tick();
        checks++;
        if (bus.out_channel !== 4'd0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL reset_first_out got ch=%0d v=%b exp ch=0 v=1", bus.out_channel, bus.out_valid);
        end
    endtask

    task automatic test_rr_fairness();
        do_reset();
        bus.mode = 0; bus.in_valid = '1; bus.out_ready = 1;
        set_data_ramp(8'h10);
        for (int c = 0; c < 17; c++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_channel) != c % C || bus.out_data !== 8'h10 + 8'(c % C)) begin
                errors++;
                $display("FAIL rr_fair[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", c, bus.out_valid,
                         bus.out_channel, bus.out_data, c % C, 8'h10 + 8'(c % C));
            end
        end
    endtask

    task automatic test_sparse();
        int exp_seq [4] = '{0, 5, 15, 0};
        do_reset();
        bus.mode = 0; bus.in_valid = 16'h8021; bus.out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_channel) != exp_seq[c]) begin
                errors++; $display("FAIL sparse[%0d] got ch=%0d v=%b exp ch=%0d", c, bus.out_channel, bus.out_valid, exp_seq[c]);
            end
        end
    endtask

    task automatic test_fixed_select();
        do_reset();
        bus.mode = 0; bus.in_valid = '1; bus.out_ready = 1;
        set_data_ramp(8'h10);
        tick();                                  // channel 0 granted, ptr -> 1
        bus.mode = 1; bus.sel = 4'd9; bus.in_data[9*N +: N] = 8'hA9;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== 16'h0200) begin errors++; $display("FAIL fixed_ready[%0d] got=%h exp=0200", c, bus.in_ready); end
            tick();
            checks++;
            if (bus.out_data !== 8'hA9 || bus.out_channel !== 4'd9) begin
                errors++; $display("FAIL fixed_out[%0d] got d=%h ch=%0d exp d=a9 ch=9", c, bus.out_data, bus.out_channel);
            end
        end
        bus.mode = 0;
        #1;
        checks++;
        if (bus.in_ready !== 16'h0002) begin errors++; $display("FAIL fixed_ptr_kept got=%h exp=0002", bus.in_ready); end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.mode = 0; bus.out_ready = 1; bus.in_valid = 16'h0008;
        set_data_ramp(8'h40);
        bus.in_data[3*N +: N] = 8'h3C;
        tick();                                  // FULL with 3C, ptr -> 4
        bus.out_ready = 0; bus.in_valid = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== '0) begin errors++; $display("FAIL bp_ready[%0d] got=%h exp=0", c, bus.in_ready); end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.out_channel !== 4'd3) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d exp v=1 d=3c ch=3", c, bus.out_valid, bus.out_data, bus.out_channel);
            end
        end
        bus.out_ready = 1;
        #1;
        checks++;
        if (bus.in_ready !== 16'h0010) begin errors++; $display("FAIL bp_release_ready got=%h exp=0010", bus.in_ready); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h44 || bus.out_channel !== 4'd4) begin
            errors++; $display("FAIL bp_no_bubble got v=%b d=%h ch=%0d exp v=1 d=44 ch=4", bus.out_valid, bus.out_data, bus.out_channel);
        end
    endtask

    task automatic test_random();
        logic [C-1:0] er;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst           = ($urandom_range(0, 99) < 3);
            bus.mode      = ($urandom_range(0, 3) == 0);
            bus.sel       = SW'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = (c % 2 == 0) ? C'($urandom) : C'($urandom & $urandom & $urandom);
            for (int k = 0; k < C; k++) bus.in_data[k*N +: N] = N'($urandom);
            #1;
            er = exp_ready();
            checks++;
            if (bus.in_ready !== er) begin errors++; $display("FAIL rand_ready[%0d] got=%h exp=%h", c, bus.in_ready, er); end
            tick();
            checks++;
            if (bus.out_valid !== m_valid || (m_valid && (bus.out_data !== m_data || int'(bus.out_channel) != m_ch))) begin
                errors++;
                $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d exp v=%b d=%h ch=%0d", c, bus.out_valid,
                         bus.out_data, bus.out_channel, m_valid, m_data, m_ch);
            end
        end
        rst = 1'b0;
    endtask

`ifdef MUX_RR_XFER_CNT_EN
    task automatic test_xfer_count();
        do_reset();
        bus.mode = 0; bus.in_valid = '1; bus.out_ready = 1;
        for (int c = 0; c < 21; c++) tick();     // first edge only loads; 20 handshakes follow
        checks++;
        if (xfer_count !== 16'd20) begin errors++; $display("FAIL cnt_20 got=%0d exp=20", xfer_count); end
        do_reset();
        checks++;
        if (xfer_count !== 16'd0) begin errors++; $display("FAIL cnt_reset got=%0d exp=0", xfer_count); end
        tick();                                  // output now FULL
        force dut.xfer_count_q = 16'hFFFF;
        tick();
        release dut.xfer_count_q;
        tick();
        checks++;
        if (xfer_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got=%h exp=ffff", xfer_count); end
    endtask
`endif

    initial begin
        bus.in_data = '0; bus.in_valid = '0; bus.mode = 0; bus.sel = '0; bus.out_ready = 0;
        @(posedge clk); #1;
        test_reset();
        test_rr_fairness();
        test_sparse();
        test_fixed_select();
        test_backpressure();
        test_random();
`ifdef MUX_RR_XFER_CNT_EN
        test_xfer_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
